// File: rtl/core_fque_pkg.sv
// Shared types and default sizes for the free-queue pointer cache.
package core_fque_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDrain
    } fq_state_e;

    localparam int unsigned DefBitQPtr  = 5;
    localparam int unsigned DefPfCnt    = 4;
    localparam int unsigned DefRetCnt   = 4;
    localparam int unsigned DefLowMark  = 2;

endpackage

// File: rtl/core_ptr_sfifo.sv
// Small synchronous pointer FIFO. Write and read may occur in the same cycle at any
// occupancy; a read of an empty FIFO is ignored, a write to a full FIFO needs a read.
module core_ptr_sfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] cnt_o,
    output logic [WIDTH-1:0]       head_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = IdxW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             full, do_push, do_pop;

    // Indices wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(DEPTH - 1)) begin
            return '0;
        end
        return idx + IdxW'(1);
    endfunction

    assign full    = (cnt_q == CntW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (!full || do_pop);

    // Next-state for indices and occupancy.
    always_comb begin
        rd_d  = do_pop ? idx_inc(rd_q) : rd_q;
        wr_d  = do_push ? idx_inc(wr_q) : wr_q;
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    // Index and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_q];

endmodule

// File: rtl/core_fque_ptr_cache.sv
// Pointer cache in front of a free queue: prefetches pointers for fast allocation,
// batches released pointers back to the queue, and drains the prefetch pool on flush.
// Optional feature: define CORE_FQUE_PTR_CACHE_STATS_EN to add alloc/free counters.
module core_fque_ptr_cache
    import core_fque_pkg::*;
#(
    parameter int unsigned BITQPTR = DefBitQPtr,
    parameter int unsigned PFCNT   = DefPfCnt,
    parameter int unsigned RETCNT  = DefRetCnt,
    parameter int unsigned LOWMARK = DefLowMark
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fq_ready,
    input  logic [BITQPTR:0]   fq_freecnt,
    output logic               fq_pop,
    input  logic               fq_po_pvld,
    input  logic [BITQPTR-1:0] fq_po_ptr,
    output logic               fq_push,
    output logic [BITQPTR-1:0] fq_pu_ptr,
    output logic               alloc_vld,
    input  logic               alloc_rdy,
    output logic [BITQPTR-1:0] alloc_ptr,
    input  logic               free_vld,
    output logic               free_rdy,
    input  logic [BITQPTR-1:0] free_ptr,
    input  logic               flush,
    output logic               flush_done,
    output logic               err
`ifdef CORE_FQUE_PTR_CACHE_STATS_EN
    ,
    output logic [31:0]        alloc_total,
    output logic [31:0]        free_total
`endif
);

    localparam int unsigned PfCntW  = $clog2(PFCNT) + 1;
    localparam int unsigned RetCntW = $clog2(RETCNT) + 1;
    localparam int unsigned SumW    = PfCntW + 1;

    fq_state_e          state_q;
    logic [PfCntW-1:0]  pf_cnt, outst_q, outst_d;
    logic [RetCntW-1:0] ret_cnt;
    logic [BITQPTR-1:0] pf_head, ret_head;
    logic               err_q, err_d;
    logic               in_fill_run, room, ret_full;
    logic               alloc_fire, free_fire, drain_push, ret_push, pf_pop, drain_done;
    logic               pvld_dec;

    core_ptr_sfifo #(
        .DEPTH (PFCNT),
        .WIDTH (BITQPTR)
    ) u_pf_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fq_po_pvld),
        .wdata_i (fq_po_ptr),
        .pop_i   (pf_pop),
        .cnt_o   (pf_cnt),
        .head_o  (pf_head)
    );

    core_ptr_sfifo #(
        .DEPTH (RETCNT),
        .WIDTH (BITQPTR)
    ) u_ret_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (free_fire),
        .wdata_i (free_ptr),
        .pop_i   (ret_push),
        .cnt_o   (ret_cnt),
        .head_o  (ret_head)
    );

    // Handshakes, pop gating and push source selection.
    always_comb begin
        in_fill_run = (state_q == StFill) || (state_q == StRun);
        // In-flight pops count against the pool so the prefetch FIFO can never overflow.
        room        = (SumW'(pf_cnt) + SumW'(outst_q)) < SumW'(PFCNT);
        fq_pop      = in_fill_run && fq_ready && (fq_freecnt != '0) && room;

        alloc_vld   = (state_q == StRun) && (pf_cnt != '0);
        alloc_fire  = alloc_vld && alloc_rdy;
        alloc_ptr   = alloc_vld ? pf_head : '0;

        ret_full    = (ret_cnt == RetCntW'(RETCNT));
        free_rdy    = !rst && !ret_full;
        free_fire   = free_vld && free_rdy;

        drain_push  = (state_q == StDrain) && (pf_cnt != '0);
        ret_push    = (state_q != StDrain) && (ret_cnt != '0);
        fq_push     = drain_push || ret_push;
        fq_pu_ptr   = drain_push ? pf_head : (ret_push ? ret_head : '0);
        pf_pop      = alloc_fire || drain_push;

        drain_done  = (state_q == StDrain) && (outst_q == '0) && (pf_cnt == '0);
        flush_done  = drain_done;

        // A zero-latency return in the same cycle as its pop is not an error.
        pvld_dec    = fq_po_pvld && ((outst_q != '0) || fq_pop);
        outst_d     = outst_q + PfCntW'(fq_pop) - PfCntW'(pvld_dec);
        err_d       = err_q || (fq_po_pvld && (outst_q == '0) && !fq_pop);
    end

    // Outstanding pop counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    // Cache control FSM; flush takes priority over the fill-complete transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (fq_ready) state_q <= StFill;
                StFill: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (pf_cnt >= PfCntW'(LOWMARK)) begin
                        state_q <= StRun;
                    end
                end
                StRun:   if (flush) state_q <= StDrain;
                StDrain: if (drain_done) state_q <= StFill;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CORE_FQUE_PTR_CACHE_STATS_EN
    logic [31:0] alloc_total_q, free_total_q;

    // Wrapping handshake counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_total_q <= '0;
            free_total_q  <= '0;
        end else begin
            if (alloc_fire) alloc_total_q <= alloc_total_q + 32'd1;
            if (free_fire)  free_total_q  <= free_total_q + 32'd1;
        end
    end

    assign alloc_total = alloc_total_q;
    assign free_total  = free_total_q;
`endif

endmodule

// File: doc/core_fque_ptr_cache.md
CORE_FQUE_PTR_CACHE -- requirements
Module: core_fque_ptr_cache

Interface
REQ-001 SHALL have parameter BITQPTR, default 5, giving the pointer width in bits.
REQ-002 SHALL have parameter PFCNT, default 4, giving the prefetch pool depth (2..16).
REQ-003 SHALL have parameter RETCNT, default 4, giving the return FIFO depth (2..16).
REQ-004 SHALL have parameter LOWMARK, default 2, giving the FILL to RUN occupancy threshold (1..PFCNT).
REQ-005 clk  in  1  single clock; all state SHALL be on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 fq_ready  in  1  free queue initialised.
REQ-008 fq_freecnt  in  BITQPTR+1  free queue occupancy.
REQ-009 fq_pop  out  1  pop request to free queue.
REQ-010 fq_po_pvld / fq_po_ptr  in  1 / BITQPTR  popped pointer return, any latency 0..2.
REQ-011 fq_push / fq_pu_ptr  out  1 / BITQPTR  pointer return to free queue.
REQ-012 alloc_vld / alloc_rdy / alloc_ptr  out / in / out  1 / 1 / BITQPTR  client allocation handshake.
REQ-013 free_vld / free_rdy / free_ptr  in / out / in  1 / 1 / BITQPTR  client release handshake.
REQ-014 flush / flush_done  in / out  1 / 1  return all cached pointers; done is a one-cycle pulse.
REQ-015 err  out  1  sticky; set when fq_po_pvld arrives with zero outstanding pops.

Function
REQ-016 FSM states SHALL be IDLE, FILL, RUN and DRAIN.
REQ-017 IDLE SHALL move to FILL on fq_ready.
REQ-018 FILL SHALL move to RUN when pf_cnt>=LOWMARK.
REQ-019 flush in FILL or RUN SHALL move the FSM to DRAIN; flush is ignored in IDLE and DRAIN.
REQ-020 DRAIN SHALL move to FILL when outstanding==0 and pf_cnt==0, pulsing flush_done in that cycle.
REQ-021 fq_pop SHALL be driven as (FILL|RUN) & fq_ready & fq_freecnt!=0 & (pf_cnt+outstanding<PFCNT); at most one pop per cycle.
REQ-022 outstanding SHALL be updated as +fq_pop -fq_po_pvld each cycle; simultaneous pop and pvld leaves it unchanged.
REQ-023 Each fq_po_pvld SHALL write fq_po_ptr to the prefetch FIFO tail, in DRAIN as well.
REQ-024 alloc_vld SHALL equal RUN & pf_cnt!=0; alloc_ptr SHALL be the prefetch head.
REQ-025 A cycle with alloc_vld & alloc_rdy SHALL pop the head.
REQ-026 alloc_ptr SHALL be stable while alloc_vld=1 and alloc_rdy=0.
REQ-027 In RUN, pf_cnt SHALL drop below LOWMARK without changing state; the FSM does not return to FILL.
REQ-028 free_rdy SHALL equal !ret_full; a free handshake SHALL write free_ptr to the return FIFO, also in DRAIN.
REQ-029 Push source in DRAIN SHALL be the prefetch head (fq_push=pf_cnt!=0), popping one entry per cycle.
REQ-030 Push source in all other states SHALL be the return FIFO head (fq_push=ret_cnt!=0).
REQ-031 Free-to-push latency SHALL be at least 1 cycle; there is no combinational bypass.
REQ-032 Simultaneous FIFO write and read SHALL be legal at any occupancy, including full (prefetch) and empty (write only).
REQ-033 Pointer wrap of both FIFO indices SHALL be modulo depth; counts are $clog2(depth)+1 bits wide.

Reset
REQ-034 Reset SHALL force state=IDLE, pf_cnt=ret_cnt=outstanding=0 and err=0.
REQ-035 Reset SHALL force all outputs to 0 (alloc_ptr and fq_pu_ptr to 0); free_rdy=1 is permitted once rst deasserts.
REQ-036 Reset mid-operation SHALL discard cached pointers; the free queue is reset concurrently by the same rst.

Configuration
REQ-037 With CORE_FQUE_PTR_CACHE_STATS_EN defined, the block SHALL add outputs alloc_total and free_total (32-bit, wrap, reset 0), incremented per alloc and free handshake.
REQ-038 Without CORE_FQUE_PTR_CACHE_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-039 State enum and default widths SHALL live in package core_fque_pkg.
REQ-040 Both FIFOs SHALL be instances of a single sub-module core_ptr_sfifo (parameters DEPTH, WIDTH; push/pop/cnt/head).

Verification
REQ-041 Reset, fq_ready=1 at cycle 3, ptrs 0,1,2,3 returned with latency 1 -> RUN after 2nd ptr; alloc_ptr=0; fq_pop stops at pf_cnt+outstanding=4.
REQ-042 alloc_rdy=1 for 6 cycles with fq_freecnt=16 -> alloc_ptr sequence matches pop order; no gaps after the first 4 allocations.
REQ-043 free_vld with ptrs 9,10,11,12,13 back-to-back, fq side idle -> all five accepted; fq_push=1 on consecutive cycles, one cycle after each write.
REQ-044 fq_freecnt=0 -> fq_pop=0; alloc_vld drops when pool empty; resumes after fq_freecnt=3.
REQ-045 flush in RUN with pf_cnt=3 and 1 pop outstanding -> 4 pushes, then flush_done pulse, then FILL.
REQ-046 fq_po_pvld with outstanding=0 -> err=1 and stays 1 until rst.
